// File: rtl/hex_display_pkg.sv
// hex_display_pkg: shared FSM encoding, blank pattern and client grant encoding
package hex_display_pkg;
    typedef enum logic {IDLE, DECODE} state_t;
    localparam logic [6:0] SEG_BLANK = 7'h7f;
    localparam logic CLIENT_A = 1'b0;
    localparam logic CLIENT_B = 1'b1;
endpackage

// File: rtl/hex_decoder.sv
// hex_decoder: 4-bit value to active-low seven-segment pattern, bit 6 = g
module hex_decoder (
    input  logic [3:0] value,
    output logic [6:0] seg
);
    // lookup of the active-low segment pattern
    always_comb begin
        case (value)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h18;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            default: seg = 7'h0E;
        endcase
    end
endmodule

// File: rtl/hex_display_arbiter.sv
// hex_display_arbiter: two-client writer into a bank of blinking seven-segment digits
module hex_display_arbiter
    import hex_display_pkg::*;
#(
    parameter int NUM_DIGITS = 6,
    parameter int BLINK_DIV  = 25000000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    a_valid,
    output logic                    a_ready,
    input  logic [2:0]              a_idx,
    input  logic [3:0]              a_value,
    input  logic                    a_blank,
    input  logic                    b_valid,
    output logic                    b_ready,
    input  logic [2:0]              b_idx,
    input  logic [3:0]              b_value,
    input  logic                    b_blank,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    output logic [7*NUM_DIGITS-1:0] hex_out,
    output logic                    busy,
    output logic                    idx_err
);
    localparam int CW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;

    state_t         state, state_nx;
    logic           last_grant, grant, xfer;
    logic [2:0]     p_idx;
    logic [3:0]     p_value;
    logic           p_blank;
    logic [6:0]     seg;
    logic [6:0]     digits [NUM_DIGITS];
    logic [CW-1:0]  cnt;
    logic           phase;

    hex_decoder u_dec (.value(p_value), .seg(seg));

    // state register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // grant: sole requester wins, a tie or no request favours the client not granted last
    always_comb begin
        grant    = (a_valid ^ b_valid) ? b_valid : ~last_grant;
        xfer     = (state == IDLE) && (grant == CLIENT_A ? a_valid : b_valid);
        state_nx = (state == IDLE && xfer) ? DECODE : IDLE;
    end

    // handshake and status outputs
    always_comb begin
        a_ready = (state == IDLE) && (grant == CLIENT_A);
        b_ready = (state == IDLE) && (grant == CLIENT_B);
        busy    = (state == DECODE);
    end

    // capture the accepted write for the decode cycle
    always_ff @(posedge clk) begin
        if (xfer) begin
            p_idx   <= grant == CLIENT_A ? a_idx   : b_idx;
            p_value <= grant == CLIENT_A ? a_value : b_value;
            p_blank <= grant == CLIENT_A ? a_blank : b_blank;
        end
    end

    // arbitration history and sticky out-of-range flag
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant <= CLIENT_B;
            idx_err    <= 1'b0;
        end else begin
            if (xfer) last_grant <= grant;
            if (state == DECODE && int'(p_idx) >= NUM_DIGITS) idx_err <= 1'b1;
        end
    end

    // digit registers, written only at the end of a decode cycle
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (reset) digits[i] <= SEG_BLANK;
            else if (state == DECODE && int'(p_idx) == i) digits[i] <= p_blank ? SEG_BLANK : seg;
        end
    end

    // free-running blink timebase, phase flips each time the counter wraps
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt   <= '0;
            phase <= 1'b0;
        end else if (cnt == CW'(BLINK_DIV - 1)) begin
            cnt   <= '0;
            phase <= ~phase;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    genvar g;
    generate
        for (g = 0; g < NUM_DIGITS; g++) begin : g_out
            assign hex_out[7*g +: 7] = (phase && blink_mask[g]) ? SEG_BLANK : digits[g];
        end
    endgenerate
endmodule

// File: tb/tb_hex_display_arbiter.sv
// tb_hex_display_arbiter: directed plus randomized check against a behavioural display model
module tb_hex_display_arbiter;
    localparam int ND = 6;
    localparam int BD = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          a_valid = 1'b0, b_valid = 1'b0, a_blank = 1'b0, b_blank = 1'b0;
    logic [2:0]    a_idx = '0, b_idx = '0;
    logic [3:0]    a_value = '0, b_value = '0;
    logic [ND-1:0] blink_mask = '0;
    logic [7*ND-1:0] hex_out;
    logic          a_ready, b_ready, busy, idx_err;

    hex_display_arbiter #(.NUM_DIGITS(ND), .BLINK_DIV(BD)) dut (
        .clk(clk), .reset(reset),
        .a_valid(a_valid), .a_ready(a_ready), .a_idx(a_idx), .a_value(a_value), .a_blank(a_blank),
        .b_valid(b_valid), .b_ready(b_ready), .b_idx(b_idx), .b_value(b_value), .b_blank(b_blank),
        .blink_mask(blink_mask), .hex_out(hex_out), .busy(busy), .idx_err(idx_err)
    );

    always #5 clk = ~clk;

    int errs = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // model: digit contents, one pending write, who was granted last, cycles since reset
    logic [6:0] m_dig [8];
    int         m_cyc;
    bit         m_busy, m_last, m_err, m_blank;
    logic [2:0] m_idx;
    logic [3:0] m_val;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // the tie winner is the client not granted last; a lone requester always wins (0 = A, 1 = B)
    function automatic bit winner(input bit av, input bit bv, input bit last);
        if (av && !bv) return 1'b0;
        if (bv && !av) return 1'b1;
        return !last;
    endfunction

    function automatic logic [7*ND-1:0] exp_hex();
        logic [7*ND-1:0] h;
        bit ph;
        ph = ((m_cyc / BD) % 2) == 1;
        for (int i = 0; i < ND; i++) h[7*i +: 7] = (ph && blink_mask[i]) ? 7'h7f : m_dig[i];
        return h;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_busy = 0; m_last = 1; m_cyc = 0; m_err = 0;
            for (int i = 0; i < 8; i++) m_dig[i] = 7'h7f;
        end else begin
            m_cyc++;
            if (m_busy) begin
                if (m_idx < ND) m_dig[m_idx] = m_blank ? 7'h7f : seg_tab[m_val];
                else m_err = 1;
                m_busy = 0;
            end else if (!winner(a_valid, b_valid, m_last) && a_valid) begin
                m_idx = a_idx; m_val = a_value; m_blank = a_blank; m_last = 0; m_busy = 1;
            end else if (winner(a_valid, b_valid, m_last) && b_valid) begin
                m_idx = b_idx; m_val = b_value; m_blank = b_blank; m_last = 1; m_busy = 1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("hex_out", 64'(hex_out), 64'(exp_hex()));
            check("a_ready", 64'(a_ready), 64'(!m_busy && !winner(a_valid, b_valid, m_last)));
            check("b_ready", 64'(b_ready), 64'(!m_busy && winner(a_valid, b_valid, m_last)));
            check("busy", 64'(busy), 64'(m_busy));
            check("idx_err", 64'(idx_err), 64'(m_err));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int cnt;
        cyc();
        chk_en = 1'b1;
        cyc();
        reset = 1'b0;
        @(negedge clk);
        check("reset_hex", 64'(hex_out), 64'({ND{7'h7f}}));
        check("reset_a_ready", 64'(a_ready), 64'd1);
        check("reset_idx_err", 64'(idx_err), 64'd0);

        cyc();
        a_valid = 1; a_idx = 0; a_value = 4'hA;
        cyc();
        a_valid = 0;
        @(negedge clk);
        check("wr_busy", 64'(busy), 64'd1);
        check("wr_a_ready", 64'(a_ready), 64'd0);
        cyc();
        @(negedge clk);
        check("wr_digit0", 64'(hex_out[6:0]), 64'h08);

        cyc();
        a_valid = 1; a_idx = 1; a_value = 4'h3;
        b_valid = 1; b_idx = 2; b_value = 4'hC;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("alt_a_ready", 64'(a_ready), 64'(k % 4 == 2));
            check("alt_b_ready", 64'(b_ready), 64'(k % 4 == 0));
            cyc();
        end
        a_valid = 0; b_valid = 0;
        cyc();
        @(negedge clk);
        check("alt_digit1", 64'(hex_out[13:7]), 64'h30);
        check("alt_digit2", 64'(hex_out[20:14]), 64'h46);

        cyc();
        b_valid = 1; b_idx = 7; b_value = 4'h1;
        cyc();
        b_valid = 0;
        cyc();
        @(negedge clk);
        check("oob_idx_err", 64'(idx_err), 64'd1);
        check("oob_hex", 64'(hex_out), 64'({7'h7f, 7'h7f, 7'h7f, 7'h46, 7'h30, 7'h08}));
        cyc();
        a_valid = 1; a_idx = 4; a_value = 4'h0;
        cyc();
        a_valid = 0;
        cyc();
        @(negedge clk);
        check("oob_sticky", 64'(idx_err), 64'd1);

        cyc();
        a_valid = 1; a_idx = 3; a_value = 4'h5;
        cyc();
        a_valid = 0;
        cyc();
        blink_mask = 6'b001000;
        cnt = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (hex_out[27:21] == 7'h7f) cnt++;
            check("blink_digit4_steady", 64'(hex_out[34:28]), 64'h40);
            cyc();
        end
        check("blink_dark_cycles", 64'(cnt), 64'd4);
        blink_mask = '0;

        a_valid = 1; a_idx = 0; a_value = 4'h8;
        @(negedge clk);
        if (!a_ready) cyc();
        cyc();
        a_valid = 0;
        reset = 1;
        cyc();
        reset = 0;
        @(negedge clk);
        check("rst_dec_busy", 64'(busy), 64'd0);
        check("rst_dec_a_ready", 64'(a_ready), 64'd1);
        check("rst_dec_digit0", 64'(hex_out[6:0]), 64'h7f);

        for (int k = 0; k < 800; k++) begin
            cyc();
            a_valid = 1'($urandom_range(0, 2) != 0);
            b_valid = 1'($urandom_range(0, 2) != 0);
            a_idx = 3'($urandom_range(0, 7)); b_idx = 3'($urandom_range(0, 7));
            a_value = 4'($urandom); b_value = 4'($urandom);
            a_blank = 1'($urandom_range(0, 7) == 0); b_blank = 1'($urandom_range(0, 7) == 0);
            if (k % 40 == 0) blink_mask = ND'($urandom);
            reset = 1'($urandom_range(0, 99) == 0);
        end
        cyc();
        reset = 0; a_valid = 0; b_valid = 0;
        cyc();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/hex_display_arbiter.md
Name: hex_display_arbiter

Overview:
- Shares one hex_decoder instance between two write clients: A (game FSM) and B (debug/score path).
- Each client writes a 4-bit value, or a blank, into one of NUM_DIGITS seven-segment digit registers.
- Drives the board HEX outputs with active-low patterns and adds per-digit blinking.
- Sits between the game control logic and the HEX pins.

Parameters:
- NUM_DIGITS, 6, number of seven-segment digits driven (1..8).
- BLINK_DIV, 25000000, clock cycles per blink half-period (>= 2).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- a_valid  in  1  client A write request
- a_ready  out  1  client A request accepted this cycle
- a_idx  in  3  client A target digit
- a_value  in  4  client A hex value
- a_blank  in  1  client A: write blank instead of value
- b_valid, b_ready, b_idx, b_value, b_blank  as client A, for client B
- blink_mask  in  NUM_DIGITS  1 = digit blinks
- hex_out  out  7*NUM_DIGITS  digit i at bits [7i+6:7i], active-low, bit 6 = segment g
- busy  out  1  FSM in DECODE
- idx_err  out  1  sticky: an out-of-range index was accepted

Behaviour:
- Clocking and reset:
  - Single clock domain; everything updates on the rising edge of clk.
  - Reset is synchronous and active-high.
  - Reset values: state=IDLE; all digit registers 7'h7f (blank); last_grant=B, so A wins the first tie; blink counter 0; phase 0; idx_err 0.
  - Reset during DECODE discards the pending write.
- FSM states: IDLE, DECODE.
- IDLE:
  - Grant is combinational.
  - Only A valid -> grant A. Only B valid -> grant B. Both valid -> grant the client that is not last_grant.
  - a_ready/b_ready are high only for the granted client, only in IDLE, independent of that client's valid being settled.
  - Transfer = valid & ready.
  - On transfer: latch idx, value and blank into the pending register; update last_grant; go to DECODE.
  - No transfer -> stay in IDLE; last_grant is unchanged.
- DECODE:
  - Both ready outputs low; busy=1.
  - The pending value drives the shared hex_decoder.
  - At the clock edge, digit[pending_idx] <= blank ? 7'h7f : decoder segments. Then go to IDLE.
  - If pending_idx >= NUM_DIGITS: no digit written, idx_err set to 1. It stays set until reset.
- Timing:
  - Write latency: a transfer in cycle N is visible on hex_out in cycle N+2 (first cycle after the DECODE edge).
  - Throughput: one write per 2 cycles.
  - Two sustained requesters alternate A, B, A, ...
- Decoder table (active-low): 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=18, A=08, B=03, C=46, D=21, E=06, F=0E (hex, 7 bits).
- Blink:
  - Counter runs 0..BLINK_DIV-1 continuously and wraps to 0. Phase toggles on the wrap.
  - hex_out digit i = 7'h7f when phase=1 && blink_mask[i]; otherwise digit register i.
  - hex_out is combinational from registers only: no combinational path from the request inputs.
  - The blink counter is unaffected by writes.
- Simultaneous events:
  - A write to a blinking digit during phase 1 updates the register; the new value appears when phase returns to 0.
  - Changes to blink_mask take effect in the same cycle.

Decomposition:
- Shared package hex_display_pkg holds:
  - the state encoding (IDLE, DECODE);
  - the constant SEG_BLANK = 7'h7f;
  - the constant CLIENT_A / CLIENT_B grant encoding.
- Instantiate the existing hex_decoder module once as the only sub-module. No new sub-module.

Test Plan:
- Reset with BLINK_DIV=4 -> hex_out all 7'h7f, a_ready=1 (A wins the first tie), idx_err=0.
- A writes idx=0, value=4'hA in cycle N -> cycle N+1: busy=1, a_ready=0; cycle N+2: hex_out[6:0]=7'h08.
- A and B both valid continuously, A idx=1 value=3, B idx=2 value=C -> grants A, B, A, B on alternate IDLE cycles; digit1=7'h30, digit2=7'h46.
- B writes idx=7 with NUM_DIGITS=6 -> no hex_out change, idx_err=1 and stays 1 after further valid writes.
- Digit 3 holds 5 (7'h12), blink_mask=6'b001000, BLINK_DIV=4 -> digit 3 alternates 7'h12 / 7'h7f every 4 cycles; other digits are steady.
- Reset asserted in DECODE for a pending write of idx=0 value=8 -> digit 0 stays 7'h7f, state IDLE the next cycle.
